// File: rtl/count_seq_checker.sv
// Watches a free-running mod-8 up-counter: locks onto it, flags sequence
// breaks, and counts 7->0 wraps seen while locked.
module count_seq_checker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] count,
  input  logic       en,
  input  logic       clr,
  output logic       locked,
  output logic       err,
  output logic [3:0] err_cnt,
  output logic [7:0] wrap_cnt,
  output logic       wrap_pulse,
  output logic [2:0] last_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t     state_q;
  logic       locked_q;
  logic       err_q;
  logic [3:0] err_cnt_q;
  logic [7:0] wrap_cnt_q;
  logic       wrap_pulse_q;
  logic [2:0] last_count_q;

  logic [2:0] expected_d;
  logic       match_d;
  logic       err_evt_d;
  logic       wrap_evt_d;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    logic [3:0] r;
    if (v == 4'hF) begin
      r = v;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

  // Only comparisons made while already locked produce error/wrap events.
  assign expected_d = last_count_q + 3'd1;
  assign match_d    = (count == expected_d);
  assign err_evt_d  = en && (state_q == TRACK) && !match_d;
  assign wrap_evt_d = en && (state_q == TRACK) && match_d && (last_count_q == 3'd7);

  // FSM plus all registered outputs; clr touches only the counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= 4'd0;
      wrap_cnt_q   <= 8'd0;
      wrap_pulse_q <= 1'b0;
      last_count_q <= 3'd0;
    end else begin
      if (!en) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q      <= SYNC;
            locked_q     <= 1'b0;
            last_count_q <= count;
          end
          SYNC: begin
            last_count_q <= count;
            if (match_d) begin
              state_q  <= TRACK;
              locked_q <= 1'b1;
            end else begin
              state_q  <= SYNC;
              locked_q <= 1'b0;
            end
          end
          TRACK: begin
            last_count_q <= count;
            if (match_d) begin
              state_q  <= TRACK;
              locked_q <= 1'b1;
            end else begin
              state_q  <= FAULT;
              locked_q <= 1'b0;
            end
          end
          FAULT: begin
            state_q      <= SYNC;
            locked_q     <= 1'b0;
            last_count_q <= count;
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end

      if (clr) begin
        err_q        <= 1'b0;
        err_cnt_q    <= 4'd0;
        wrap_cnt_q   <= 8'd0;
        wrap_pulse_q <= 1'b0;
      end else begin
        if (err_evt_d) begin
          err_q     <= 1'b1;
          err_cnt_q <= sat_inc4(err_cnt_q);
        end
        if (wrap_evt_d) begin
          wrap_cnt_q <= wrap_cnt_q + 8'd1;
        end
        wrap_pulse_q <= wrap_evt_d;
      end
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_cnt    = err_cnt_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign wrap_pulse = wrap_pulse_q;
  assign last_count = last_count_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] count;
  logic       en;
  logic       clr;
  logic       locked;
  logic       err;
  logic [3:0] err_cnt;
  logic [7:0] wrap_cnt;
  logic       wrap_pulse;
  logic [2:0] last_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  count_seq_checker dut (
    .clk(clk), .rst_n(rst_n), .count(count), .en(en), .clr(clr),
    .locked(locked), .err(err), .err_cnt(err_cnt), .wrap_cnt(wrap_cnt),
    .wrap_pulse(wrap_pulse), .last_count(last_count)
  );

  // Behavioural model: "seen" = an enabled sample exists since the last idle,
  // "locked"/"recovering" describe whether the next sample is being judged.
  bit m_seen, m_locked, m_recovering, m_err, m_pulse;
  int m_last, m_errs, m_wraps;

  task automatic model_reset();
    m_seen = 1'b0; m_locked = 1'b0; m_recovering = 1'b0;
    m_err = 1'b0; m_pulse = 1'b0; m_last = 0; m_errs = 0; m_wraps = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input int v);
    bit hit, err_ev, wrap_ev;
    hit     = (v == (m_last + 1) % 8);
    err_ev  = e && m_locked && !hit;
    wrap_ev = e && m_locked && hit && (v == 0);
    if (!e) begin
      m_seen = 1'b0; m_locked = 1'b0; m_recovering = 1'b0;
    end else if (!m_seen) begin
      m_seen = 1'b1; m_locked = 1'b0; m_last = v;
    end else if (m_recovering) begin
      m_recovering = 1'b0; m_locked = 1'b0; m_last = v;
    end else begin
      m_recovering = m_locked && !hit;
      m_locked = hit;
      m_last = v;
    end
    if (c) begin
      m_err = 1'b0; m_errs = 0; m_wraps = 0; m_pulse = 1'b0;
    end else begin
      if (err_ev) begin
        m_err = 1'b1;
        m_errs = (m_errs + 1 > 15) ? 15 : m_errs + 1;
      end
      if (wrap_ev) m_wraps = (m_wraps + 1) % 256;
      m_pulse = wrap_ev;
    end
  endtask

  function automatic logic [17:0] mk(input bit l, input bit e, input int ec,
                                     input int wc, input bit p, input int lc);
    return {l, e, 4'(ec), 8'(wc), p, 3'(lc)};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {locked, err, err_cnt, wrap_cnt, wrap_pulse, last_count};
  endfunction

  function automatic logic [17:0] model_vec();
    return mk(m_locked, m_err, m_errs, m_wraps, m_pulse, m_last);
  endfunction

  task automatic check_vec(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got locked=%0b err=%0b err_cnt=%0d wrap_cnt=%0d wrap_pulse=%0b last_count=%0d; want locked=%0b err=%0b err_cnt=%0d wrap_cnt=%0d wrap_pulse=%0b last_count=%0d",
               name, act[17], act[16], act[15:12], act[11:4], act[3], act[2:0],
               exp[17], exp[16], exp[15:12], exp[11:4], exp[3], exp[2:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit e, input bit c, input logic [2:0] v);
    en = e; clr = c; count = v;
    @(posedge clk);
    model_step(e, c, int'(v));
    #1;
  endtask

  task automatic step_chk(input string name, input bit e, input bit c, input logic [2:0] v);
    step(e, c, v);
    check_vec(name, dut_vec(), model_vec());
  endtask

  typedef struct {
    bit         e;
    bit         c;
    logic [2:0] v;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [2:0] v;
    logic [2:0] v2;
    int pulses;

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; count = 3'd0;
    model_reset();
    #12;
    check_vec("reset_state", dut_vec(), 18'd0);
    rst_n = 1'b1;

    // Lock, one wrap, 3->5 jump, relock, clr vs wrap, idle, stall, uncounted wrap.
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b1, 1'b0, 3'(i), mk(i != 0, 1'b0, 0, 0, 1'b0, i)});
    tbl.push_back('{1'b1, 1'b0, 3'd0, mk(1, 0, 0, 1, 1, 0)});
    tbl.push_back('{1'b1, 1'b0, 3'd1, mk(1, 0, 0, 1, 0, 1)});
    tbl.push_back('{1'b1, 1'b0, 3'd2, mk(1, 0, 0, 1, 0, 2)});
    tbl.push_back('{1'b1, 1'b0, 3'd3, mk(1, 0, 0, 1, 0, 3)});
    tbl.push_back('{1'b1, 1'b0, 3'd5, mk(0, 1, 1, 1, 0, 5)});
    tbl.push_back('{1'b1, 1'b0, 3'd6, mk(0, 1, 1, 1, 0, 6)});
    tbl.push_back('{1'b1, 1'b0, 3'd7, mk(1, 1, 1, 1, 0, 7)});
    tbl.push_back('{1'b1, 1'b1, 3'd0, mk(1, 0, 0, 0, 0, 0)});
    tbl.push_back('{1'b1, 1'b0, 3'd1, mk(1, 0, 0, 0, 0, 1)});
    tbl.push_back('{1'b0, 1'b0, 3'd3, mk(0, 0, 0, 0, 0, 1)});
    tbl.push_back('{1'b1, 1'b0, 3'd4, mk(0, 0, 0, 0, 0, 4)});
    tbl.push_back('{1'b1, 1'b0, 3'd5, mk(1, 0, 0, 0, 0, 5)});
    tbl.push_back('{1'b1, 1'b0, 3'd5, mk(0, 1, 1, 0, 0, 5)});
    tbl.push_back('{1'b1, 1'b0, 3'd7, mk(0, 1, 1, 0, 0, 7)});
    tbl.push_back('{1'b1, 1'b0, 3'd0, mk(1, 1, 1, 0, 0, 0)});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].e, tbl[i].c, tbl[i].v);
      check_vec($sformatf("table[%0d]", i), dut_vec(), tbl[i].exp);
    end

    // Error saturation: 20 breaks, each followed by a resync.
    v = 3'd0;
    for (int i = 0; i < 20; i++) begin
      v2 = 3'(v + 3'd3);
      step_chk("err_inject", 1'b1, 1'b0, v2);
      step_chk("err_resync", 1'b1, 1'b0, 3'(v2 + 3'd1));
      v = 3'(v2 + 3'd2);
      step_chk("err_relock", 1'b1, 1'b0, v);
    end
    check_int("err_cnt_saturated", int'(err_cnt), 15);
    check_int("err_sticky", int'(err), 1);

    // 256 wraps bring wrap_cnt back to zero.
    v = 3'(v + 3'd1);
    step_chk("wrap_clr", 1'b1, 1'b1, v);
    pulses = 0;
    for (int i = 0; i < 2100 && pulses < 256; i++) begin
      v = 3'(v + 3'd1);
      step_chk("wrap_run", 1'b1, 1'b0, v);
      if (wrap_pulse === 1'b1) pulses++;
    end
    check_int("wrap_pulses_seen", pulses, 256);
    check_int("wrap_cnt_rollover", int'(wrap_cnt), 0);
    for (int i = 0; i < 24; i++) begin
      v = 3'(v + 3'd1);
      step_chk("wrap_more", 1'b1, 1'b0, v);
    end
    check_int("wrap_cnt_three", int'(wrap_cnt), 3);
    for (int i = 0; i < 5; i++)
      step_chk("en_low", 1'b0, 1'b0, 3'($urandom_range(0, 7)));
    check_int("idle_locked", int'(locked), 0);
    check_int("idle_wrap_held", int'(wrap_cnt), 3);
    check_int("idle_err_held", int'(err_cnt), 0);
    step_chk("reenable_sync", 1'b1, 1'b0, 3'd5);
    check_int("reenable_not_locked", int'(locked), 0);
    step_chk("reenable_lock", 1'b1, 1'b0, 3'd6);
    check_int("reenable_locked", int'(locked), 1);

    // Asynchronous reset mid-cycle while locked with non-zero counters.
    step_chk("pre_rst_err", 1'b1, 1'b0, 3'd2);
    step_chk("pre_rst_sync", 1'b1, 1'b0, 3'd3);
    step_chk("pre_rst_lock", 1'b1, 1'b0, 3'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("async_reset", dut_vec(), 18'd0);
    model_reset();
    #2;
    rst_n = 1'b1;
    step_chk("post_rst_1", 1'b1, 1'b0, 3'd5);
    check_int("post_rst_unlocked", int'(locked), 0);
    step_chk("post_rst_2", 1'b1, 1'b0, 3'd6);
    check_int("post_rst_relocked", int'(locked), 1);

    // Randomized traffic against the model.
    v = 3'd6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) v = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 15) != 0) v = 3'(v + 3'd1);
      step_chk("random", ($urandom_range(0, 15) != 0), ($urandom_range(0, 31) == 0), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
